// File: rtl/eng_pkg.sv
// eng_pkg: shared types, derived sizes and helper functions for the engine
// job sequencer (eng_ctrl) and its beat counter.
package eng_pkg;

  localparam int W                = 8;   // GF word width (bits per bitmatrix column)
  localparam int K_MAX            = 8;   // max data packets per stripe
  localparam int M_MAX            = 4;   // max parity rows per stripe
  localparam int BM_MULT_UNIT_NUM = 4;   // data packets consumed per engine beat
  localparam int STRIPE_W         = 8;   // stripe counter width
  localparam int KG_MAX           = K_MAX / BM_MULT_UNIT_NUM;
  localparam int INBUF_ADDR_W     = STRIPE_W + $clog2(KG_MAX);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } eng_ctrl_state_t;

  // A job is legal when k, m and the stripe count are all inside their ranges.
  function automatic logic cfg_legal(input int k, input int m, input int stripes,
                                     input int k_max, input int m_max);
    return (k >= 1) && (k <= k_max) && (m >= 1) && (m <= m_max) && (stripes >= 1);
  endfunction

  // Number of column groups needed to cover k packets (ceiling division).
  function automatic int grp_count(input int k, input int unit);
    return (k + unit - 1) / unit;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// beat_counter: nested grp/row/stripe counter with runtime wrap limits.
// grp is the fastest digit, then row, then stripe.
//   clk, rst        : clock, asynchronous active-high reset
//   i_clr           : synchronous clear of all three counters (wins over i_adv)
//   i_adv           : advance by one beat
//   i_*_last        : value at which each digit wraps to zero
//   o_grp/row/stripe: current counter values
//   o_last          : counters sit on the final beat of the job
module beat_counter #(
  parameter int GRP_W    = 1,
  parameter int ROW_W    = 2,
  parameter int STRIPE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_adv,
  input  logic [GRP_W-1:0]    i_grp_last,
  input  logic [ROW_W-1:0]    i_row_last,
  input  logic [STRIPE_W-1:0] i_stripe_last,
  output logic [GRP_W-1:0]    o_grp,
  output logic [ROW_W-1:0]    o_row,
  output logic [STRIPE_W-1:0] o_stripe,
  output logic                o_last
);

  logic [GRP_W-1:0]    r_grp;
  logic [ROW_W-1:0]    r_row;
  logic [STRIPE_W-1:0] r_stripe;

  // Counter update: carry ripples grp -> row -> stripe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grp    <= '0;
      r_row    <= '0;
      r_stripe <= '0;
    end else if (i_clr) begin
      r_grp    <= '0;
      r_row    <= '0;
      r_stripe <= '0;
    end else if (i_adv) begin
      if (r_grp == i_grp_last) begin
        r_grp <= '0;
        if (r_row == i_row_last) begin
          r_row <= '0;
          if (r_stripe == i_stripe_last) begin
            r_stripe <= '0;
          end else begin
            r_stripe <= r_stripe + STRIPE_W'(1);
          end
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_grp <= r_grp + GRP_W'(1);
      end
    end
  end

  assign o_grp    = r_grp;
  assign o_row    = r_row;
  assign o_stripe = r_stripe;
  assign o_last   = (r_grp == i_grp_last) && (r_row == i_row_last) &&
                    (r_stripe == i_stripe_last);

endmodule

// File: rtl/eng_ctrl.sv
// eng_ctrl: job sequencer for the bitmatrix-multiply / XOR-tree encoder.
// Walks every (stripe, parity row, column group) beat of a job, drives the
// engine advance enable, engine clear, input-buffer read and bitmatrix selects,
// stalls on output-buffer backpressure and flushes the pipeline at job end.
//   ctl_start/ctl_abort/cfg_*        : job control and configuration
//   data_used/eng_empty              : engine beat consumption / drain status
//   eng_outbuf_wr_req/outbuf_eng_wr_ack : monitored to detect backpressure
//   cntrl_eng_calc_en/eng_rstn       : engine advance enable / sync clear (low)
//   ctl_inbuf_rd_req/_addr           : input-buffer read
//   ctl_bm_grp_idx/ctl_bm_row_idx    : bitmatrix column-group / row select
//   ctl_busy/ctl_done/ctl_err        : status
module eng_ctrl #(
  parameter  int K_MAX            = eng_pkg::K_MAX,
  parameter  int M_MAX            = eng_pkg::M_MAX,
  parameter  int BM_MULT_UNIT_NUM = eng_pkg::BM_MULT_UNIT_NUM,
  parameter  int STRIPE_W         = eng_pkg::STRIPE_W,
  localparam int KG_MAX           = K_MAX / BM_MULT_UNIT_NUM,
  localparam int GRP_W            = (KG_MAX > 1) ? $clog2(KG_MAX) : 1,
  localparam int ROW_W            = (M_MAX > 1) ? $clog2(M_MAX) : 1,
  localparam int ADDR_W           = STRIPE_W + $clog2(KG_MAX),
  localparam int KW               = $clog2(K_MAX + 1),
  localparam int MW               = $clog2(M_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctl_start,
  input  logic                ctl_abort,
  input  logic [KW-1:0]       cfg_k,
  input  logic [MW-1:0]       cfg_m,
  input  logic [STRIPE_W-1:0] cfg_stripes,
  input  logic                data_used,
  input  logic                eng_empty,
  input  logic                eng_outbuf_wr_req,
  input  logic                outbuf_eng_wr_ack,
  output logic                cntrl_eng_calc_en,
  output logic                eng_rstn,
  output logic                ctl_inbuf_rd_req,
  output logic [ADDR_W-1:0]   ctl_inbuf_rd_addr,
  output logic [GRP_W-1:0]    ctl_bm_grp_idx,
  output logic [ROW_W-1:0]    ctl_bm_row_idx,
  output logic                ctl_busy,
  output logic                ctl_done,
  output logic                ctl_err
);

  import eng_pkg::*;

  eng_ctrl_state_t     r_state;
  logic [GRP_W-1:0]    r_grp_last;
  logic [ROW_W-1:0]    r_row_last;
  logic [STRIPE_W-1:0] r_stripe_last;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_eng_rstn;

  logic                w_stall;
  logic                w_abort;
  logic                w_calc_en;
  logic                w_rd_req;
  logic                w_adv;
  logic                w_clr;
  logic                w_last;
  logic                w_cfg_ok;
  logic [GRP_W-1:0]    w_grp_last_cfg;
  logic [GRP_W-1:0]    w_grp;
  logic [ROW_W-1:0]    w_row;
  logic [STRIPE_W-1:0] w_stripe;

  // Handshake, stall and config decode.
  always_comb begin
    w_stall        = eng_outbuf_wr_req & ~outbuf_eng_wr_ack;
    w_abort        = ctl_abort && (r_state != ST_IDLE);
    w_calc_en      = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_stall;
    w_rd_req       = (r_state == ST_RUN) && !w_stall;
    // data_used only counts while the engine is actually being advanced in RUN.
    w_adv          = w_rd_req && data_used;
    w_clr          = w_abort || (r_state == ST_LOAD);
    w_cfg_ok       = cfg_legal(int'(cfg_k), int'(cfg_m), int'(cfg_stripes), K_MAX, M_MAX);
    w_grp_last_cfg = GRP_W'(grp_count(int'(cfg_k), BM_MULT_UNIT_NUM) - 1);
  end

  beat_counter #(
    .GRP_W    (GRP_W),
    .ROW_W    (ROW_W),
    .STRIPE_W (STRIPE_W)
  ) u_beat_counter (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_clr),
    .i_adv         (w_adv),
    .i_grp_last    (r_grp_last),
    .i_row_last    (r_row_last),
    .i_stripe_last (r_stripe_last),
    .o_grp         (w_grp),
    .o_row         (w_row),
    .o_stripe      (w_stripe),
    .o_last        (w_last)
  );

  // Job FSM with registered status and engine-clear outputs; abort has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grp_last    <= '0;
      r_row_last    <= '0;
      r_stripe_last <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_eng_rstn    <= 1'b1;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_eng_rstn <= 1'b1;
      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_eng_rstn <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (ctl_start) begin
              if (w_cfg_ok) begin
                // Wrap limits are stored as last-index values for the counter.
                r_grp_last    <= w_grp_last_cfg;
                r_row_last    <= ROW_W'(int'(cfg_m) - 1);
                r_stripe_last <= cfg_stripes - STRIPE_W'(1);
                r_state       <= ST_LOAD;
                r_busy        <= 1'b1;
                r_eng_rstn    <= 1'b0;
              end else begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end
            end
          end
          ST_LOAD: r_state <= ST_RUN;
          ST_RUN: begin
            if (w_adv && w_last) begin
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (eng_empty && !w_stall) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          ST_ERR:  r_state <= ST_IDLE;
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cntrl_eng_calc_en = w_calc_en;
  assign ctl_inbuf_rd_req  = w_rd_req;
  // Same data group is re-read for every parity row: address ignores the row.
  assign ctl_inbuf_rd_addr = ADDR_W'(w_stripe) * ADDR_W'(KG_MAX) + ADDR_W'(w_grp);
  assign ctl_bm_grp_idx    = w_grp;
  assign ctl_bm_row_idx    = w_row;
  assign eng_rstn          = r_eng_rstn;
  assign ctl_busy          = r_busy;
  assign ctl_done          = r_done;
  assign ctl_err           = r_err;

endmodule

// File: tb/tb_eng_ctrl.sv
// tb_eng_ctrl: randomized self-checking bench for eng_ctrl. A job-level
// reference model expands each configuration into its beat list by plain
// arithmetic and predicts every output cycle by cycle.
module tb_eng_ctrl;

  localparam int KG = eng_pkg::KG_MAX;
  localparam int AW = eng_pkg::INBUF_ADDR_W;

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4, P_ERR = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctl_start, ctl_abort;
  logic [3:0]    cfg_k;
  logic [2:0]    cfg_m;
  logic [7:0]    cfg_stripes;
  logic          data_used, eng_empty, eng_outbuf_wr_req, outbuf_eng_wr_ack;
  logic          cntrl_eng_calc_en, eng_rstn, ctl_inbuf_rd_req;
  logic [AW-1:0] ctl_inbuf_rd_addr;
  logic [0:0]    ctl_bm_grp_idx;
  logic [1:0]    ctl_bm_row_idx;
  logic          ctl_busy, ctl_done, ctl_err;

  eng_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .ctl_start         (ctl_start),
    .ctl_abort         (ctl_abort),
    .cfg_k             (cfg_k),
    .cfg_m             (cfg_m),
    .cfg_stripes       (cfg_stripes),
    .data_used         (data_used),
    .eng_empty         (eng_empty),
    .eng_outbuf_wr_req (eng_outbuf_wr_req),
    .outbuf_eng_wr_ack (outbuf_eng_wr_ack),
    .cntrl_eng_calc_en (cntrl_eng_calc_en),
    .eng_rstn          (eng_rstn),
    .ctl_inbuf_rd_req  (ctl_inbuf_rd_req),
    .ctl_inbuf_rd_addr (ctl_inbuf_rd_addr),
    .ctl_bm_grp_idx    (ctl_bm_grp_idx),
    .ctl_bm_row_idx    (ctl_bm_row_idx),
    .ctl_busy          (ctl_busy),
    .ctl_done          (ctl_done),
    .ctl_err           (ctl_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int ph = P_IDLE;
  bit rstn_pulse = 1'b0;
  int mk, mm, ms, mg;
  int idx;
  int obs_beats;
  int err_cnt = 0;
  int done_cnt = 0;
  int q_addr[$];

  // One clock cycle: drive inputs after the falling edge, check, then step the model.
  task automatic cycle(input bit st, input bit ab, input bit du,
                       input bit wq, input bit ak, input bit em);
    bit stall;
    int g, r, s;
    @(negedge clk);
    ctl_start = st; ctl_abort = ab; data_used = du;
    eng_outbuf_wr_req = wq; outbuf_eng_wr_ack = ak; eng_empty = em;
    #1;
    stall = wq && !ak;
    chk("calc_en", cntrl_eng_calc_en, (ph == P_RUN || ph == P_DRAIN) && !stall);
    chk("rd_req",  ctl_inbuf_rd_req,  ph == P_RUN && !stall);
    chk("busy",    ctl_busy,          ph == P_LOAD || ph == P_RUN || ph == P_DRAIN);
    chk("done",    ctl_done,          ph == P_DONE);
    chk("err",     ctl_err,           ph == P_ERR);
    chk("eng_rstn", eng_rstn,         !(ph == P_LOAD || rstn_pulse));
    if (ph == P_RUN) begin
      g = idx % mg;
      r = (idx / mg) % mm;
      s = idx / (mg * mm);
      chk("rd_addr", ctl_inbuf_rd_addr, s * KG + g);
      chk("grp_idx", ctl_bm_grp_idx, g);
      chk("row_idx", ctl_bm_row_idx, r);
    end
    if (cntrl_eng_calc_en && ctl_inbuf_rd_req && du) obs_beats++;

    if (ph != P_IDLE && ab) begin
      ph = P_IDLE;
      rstn_pulse = 1'b1;
    end else begin
      rstn_pulse = 1'b0;
      case (ph)
        P_IDLE: if (st) begin
          if (cfg_k >= 1 && cfg_k <= 8 && cfg_m >= 1 && cfg_m <= 4 && cfg_stripes >= 1) begin
            mk = cfg_k; mm = cfg_m; ms = cfg_stripes;
            mg = (mk + 3) / 4;
            obs_beats = 0;
            q_addr.delete();
            ph = P_LOAD;
          end else begin
            ph = P_ERR;
          end
        end
        P_LOAD: begin ph = P_RUN; idx = 0; end
        P_RUN: if (du && !stall) begin
          q_addr.push_back(int'(ctl_inbuf_rd_addr));
          idx++;
          if (idx == ms * mm * mg) ph = P_DRAIN;
        end
        P_DRAIN: if (em && !stall) begin
          ph = P_DONE;
          chk("beats", obs_beats, ms * mm * mg);
        end
        P_DONE: begin ph = P_IDLE; done_cnt++; end
        P_ERR:  begin ph = P_IDLE; err_cnt++; end
        default: ph = P_IDLE;
      endcase
    end
  endtask

  // Drive one job from start until the model is back in IDLE.
  task automatic run_job(input int k, input int m, input int s, input int abort_at,
                         input int stall_at, input int used_pct, input int stall_pct,
                         input int empty_delay);
    int drain_n = 0;
    int stall_left = 4;
    bit du, wq, ak, ab, em, st;
    cfg_k = 4'(k); cfg_m = 3'(m); cfg_stripes = 8'(s);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 6000 && ph != P_IDLE; n++) begin
      du = ($urandom_range(0, 99) < used_pct);
      if ($urandom_range(0, 99) < stall_pct) begin
        wq = 1'b1; ak = 1'b0;
      end else begin
        wq = 1'($urandom_range(0, 1)); ak = 1'b1;
      end
      if (ph == P_RUN && idx == stall_at && stall_left > 0) begin
        wq = 1'b1; ak = 1'b0; du = 1'b1;
        stall_left--;
      end
      ab = (ph == P_RUN && idx == abort_at);
      em = (ph == P_DRAIN && drain_n >= empty_delay);
      if (ph == P_DRAIN) drain_n++;
      st = ($urandom_range(0, 7) == 0);
      cycle(st, ab, du, wq, ak, em);
    end
    if (ph != P_IDLE) chk("job_timeout", 1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  int exp_nom[12] = '{0, 1, 0, 1, 2, 3, 2, 3, 4, 5, 4, 5};
  int e0, d0;

  initial begin
    rst = 1'b1;
    ctl_start = 1'b0; ctl_abort = 1'b0; data_used = 1'b0; eng_empty = 1'b0;
    eng_outbuf_wr_req = 1'b0; outbuf_eng_wr_ack = 1'b1;
    cfg_k = 4'd0; cfg_m = 3'd0; cfg_stripes = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", ctl_busy, 0);
    chk("rst_rstn", eng_rstn, 1);
    chk("rst_addr", ctl_inbuf_rd_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal job: k=8 m=2 stripes=3, data_used every cycle, no stall
    d0 = done_cnt;
    run_job(8, 2, 3, -1, -1, 100, 0, 3);
    chk("nom_done", done_cnt - d0, 1);
    chk("nom_len", q_addr.size(), 12);
    for (int i = 0; i < 12 && i < q_addr.size(); i++) chk("nom_seq", q_addr[i], exp_nom[i]);

    // Partial group: k=5 m=1 stripes=1 -> two beats
    run_job(5, 1, 1, -1, -1, 100, 0, 0);
    chk("part_beats", obs_beats, 2);

    // Backpressure for 4 cycles at beat 5
    run_job(8, 2, 3, -1, 5, 100, 0, 1);
    chk("bp_beats", obs_beats, 12);

    // Illegal configurations
    e0 = err_cnt;
    run_job(9, 2, 3, -1, -1, 100, 0, 0);
    run_job(0, 2, 3, -1, -1, 100, 0, 0);
    run_job(8, 0, 3, -1, -1, 100, 0, 0);
    chk("err_pulses", err_cnt - e0, 3);

    // Abort at beat 5, then a fresh full job from address 0
    d0 = done_cnt;
    run_job(8, 2, 3, 5, -1, 100, 0, 0);
    chk("abort_nodone", done_cnt - d0, 0);
    run_job(8, 2, 3, -1, -1, 100, 0, 0);
    chk("post_abort_first", (q_addr.size() > 0) ? q_addr[0] : -1, 0);
    chk("post_abort_done", done_cnt - d0, 1);

    // Longest stripe count
    run_job(4, 4, 255, -1, -1, 100, 0, 2);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      int k, m, s, ab_at;
      k = $urandom_range(0, 9);
      m = $urandom_range(0, 5);
      s = $urandom_range(0, 6);
      if ($urandom_range(0, 3) != 0) begin
        if (k == 0 || k > 8) k = 8;
        if (m == 0 || m > 4) m = 1;
        if (s == 0) s = 2;
      end
      ab_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1;
      run_job(k, m, s, ab_at, $urandom_range(0, 6), 70, 20, $urandom_range(0, 3));
    end

    // Reset mid-DRAIN
    cfg_k = 4'd4; cfg_m = 3'd1; cfg_stripes = 8'd2;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 50 && ph != P_DRAIN; n++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("reach_drain", ph, P_DRAIN);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", ctl_busy, 0);
    chk("arst_calc", cntrl_eng_calc_en, 0);
    chk("arst_rdreq", ctl_inbuf_rd_req, 0);
    chk("arst_rstn", eng_rstn, 1);
    chk("arst_done", ctl_done, 0);
    chk("arst_err", ctl_err, 0);
    chk("arst_addr", ctl_inbuf_rd_addr, 0);
    ctl_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("start_in_rst", ctl_busy, 0);
    @(negedge clk);
    ctl_start = 1'b0;
    rst = 1'b0;
    ph = P_IDLE;
    rstn_pulse = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_job(8, 1, 2, -1, -1, 100, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eng_ctrl.md
Name: eng_ctrl

Overview:
Job sequencer for engine_top, the bitmatrix-multiply plus XOR-tree encoding pipeline. It accepts a per-job encode configuration (k data packets, m parity rows, stripe count). It steps through every (stripe, parity row, column group) beat and drives the engine calc-enable, the engine clear, the input-buffer read address and the bitmatrix row/group selects. It stalls the engine on output-buffer backpressure and flushes the pipeline at end of job.

Parameters:
W, 8, Galois-field word width (bits per bitmatrix column)
K_MAX, 8, max data packets per stripe
M_MAX, 4, max parity rows per stripe
BM_MULT_UNIT_NUM, 4, data packets consumed per engine beat; K_MAX must be a multiple of it
STRIPE_W, 8, stripe counter width
KG_MAX, K_MAX/BM_MULT_UNIT_NUM, max column groups (derived, don't override)
INBUF_ADDR_W, STRIPE_W+$clog2(KG_MAX), input-buffer read address width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ctl_start  in  1  one-cycle job start; sampled only in IDLE
ctl_abort  in  1  abandon current job
cfg_k  in  $clog2(K_MAX+1)  data packets per stripe, legal range 1..K_MAX
cfg_m  in  $clog2(M_MAX+1)  parity rows, legal range 1..M_MAX
cfg_stripes  in  STRIPE_W  stripe count, legal range 1..2^STRIPE_W-1
data_used  in  1  engine consumed current beat
eng_empty  in  1  engine holds no unwritten valid data
eng_outbuf_wr_req  in  1  engine write request (monitored)
outbuf_eng_wr_ack  in  1  output-buffer write acknowledge (monitored)
cntrl_eng_calc_en  out  1  engine pipeline advance enable
eng_rstn  out  1  synchronous active-low engine clear
ctl_inbuf_rd_req  out  1  input-buffer read request
ctl_inbuf_rd_addr  out  INBUF_ADDR_W  stripe*KG_MAX + grp
ctl_bm_grp_idx  out  $clog2(KG_MAX)  bitmatrix column-group select
ctl_bm_row_idx  out  $clog2(M_MAX)  bitmatrix parity-row select
ctl_busy  out  1  job in progress
ctl_done  out  1  one-cycle job-complete pulse
ctl_err  out  1  one-cycle illegal-config pulse

Behaviour:
- Reset values: state IDLE, all counters 0, calc_en 0, eng_rstn 1, rd_req 0, busy 0, done 0, err 0.
- G = ceil(cfg_k / BM_MULT_UNIT_NUM). The configuration and G are registered in LOAD and held stable for the whole job.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE, ERR.
- IDLE:
  - ctl_start with legal config goes to LOAD.
  - ctl_start with illegal config (k=0, k>K_MAX, m=0, m>M_MAX, stripes=0) goes to ERR.
  - ctl_start while not in IDLE is ignored.
- LOAD: one cycle. Latches the configuration, drives eng_rstn=0 to clear the engine, clears counters, then goes to RUN.
- ERR: one cycle with ctl_err=1, then IDLE.
- stall = eng_outbuf_wr_req & ~outbuf_eng_wr_ack (combinational).
- cntrl_eng_calc_en = (RUN | DRAIN) & ~stall.
- ctl_inbuf_rd_req = RUN & ~stall.
- Beat order:
  - grp increments fastest, then row, then stripe.
  - A counter advances only on data_used & cntrl_eng_calc_en; data_used while calc_en=0 is ignored.
  - grp wraps at G-1 (not KG_MAX-1), which increments row.
  - row wraps at cfg_m-1, which increments stripe.
- Address and selects: rd_addr, bm_grp_idx and bm_row_idx are combinational from the current counters and valid during RUN. The same data group is re-read for every parity row.
- When data_used is counted on the last beat (grp=G-1, row=m-1, stripe=stripes-1), the FSM goes to DRAIN. Total beats per job = stripes*m*G.
- DRAIN: calc_en stays high (except on stall) to flush the 3-stage pipeline. Leaves when eng_empty=1 and no stall, going to DONE. No drain timeout.
- DONE: one cycle with ctl_done=1, then IDLE.
- ctl_busy = 1 in LOAD, RUN and DRAIN.
- ctl_abort, in any state other than IDLE:
  - next cycle: IDLE, eng_rstn=0 for exactly one cycle, counters cleared, no done pulse.
  - Abort wins over a simultaneous data_used or start.
- rst asserted mid-job: all state returns to reset values immediately. The engine is not explicitly cleared; the system reset covers it.

Decomposition:
- Shared package eng_pkg:
  - FSM state enum eng_ctrl_state_t
  - KG_MAX and INBUF_ADDR_W derivations
  - cfg legality function
- Sub-module beat_counter: the nested grp/row/stripe counter with runtime wrap limits, advance input and last-beat output.

Test Plan:
- Nominal full job: k=8, m=2, stripes=3, data_used every cycle, no stall -> G=2; 12 beats; rd_addr sequence 0,1,0,1,2,3,2,3,4,5,4,5; ctl_done pulses one cycle after eng_empty rises in DRAIN.
- Partial group: k=5, m=1, stripes=1 -> G=2; grp goes 0,1 then DRAIN; exactly 2 beats counted.
- Backpressure: eng_outbuf_wr_req=1 and outbuf_eng_wr_ack=0 for 4 cycles mid-RUN -> calc_en and rd_req low for those 4 cycles; counters frozen; data_used pulses during the stall not counted.
- Illegal config: start with k=9, then k=0, then m=0 -> one ctl_err pulse each; busy never asserted; no eng_rstn pulse.
- Abort: abort asserted at beat 5 of 12 -> next cycle IDLE, eng_rstn low for one cycle, no done; a new start then runs a full job from rd_addr 0.
- Reset mid-DRAIN: rst pulsed -> all outputs at reset values asynchronously; start ignored while rst=1.
